// File: rtl/ingreso_pin_pkg.sv
// Shared definitions for the keypad front-end of the parking-gate controller:
// FSM state encoding, special key codes and the PIN bus width.
package ingreso_pin_pkg;

  localparam int PIN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  // Codes 0x0-0x9 are BCD digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/ingreso_pin_if.sv
// Keypad / gate-controller bundle for ingreso_pin. The master side is the
// keypad scanner plus presence/lockout sources; the slave side is ingreso_pin.
interface ingreso_pin_if;
  import ingreso_pin_pkg::*;

  logic [3:0]       Key;
  logic             KeyValid;
  logic             Vehiculo;
  logic             Bloqueo;
  logic [PIN_W-1:0] Pin;
  logic             enterPin;
  logic [1:0]       DigitCount;
  logic             Ocupado;

  modport master (
    output Key, KeyValid, Vehiculo, Bloqueo,
    input  Pin, enterPin, DigitCount, Ocupado
  );

  modport slave (
    input  Key, KeyValid, Vehiculo, Bloqueo,
    output Pin, enterPin, DigitCount, Ocupado
  );

endinterface

// File: rtl/ingreso_pin_detector_flanco.sv
// One-bit rising-edge detector: flags the first cycle a level goes high, so a
// held key produces a single press event.
module detector_flanco (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Previous-cycle copy of the level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/ingreso_pin.sv
// Keypad front-end: assembles two BCD digits into Pin and strobes enterPin
// once when Enter follows a complete PIN. Entry is only possible while a
// vehicle is present and the gate controller is not locked out.
// Optional build macro INGRESO_TIMEOUT_EN adds an inactivity timeout that
// discards a partial entry after TIMEOUT_CYCLES idle cycles in DIG1/DIG2.
module ingreso_pin
  import ingreso_pin_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input logic        Clk,
  input logic        Reset,
  ingreso_pin_if.slave bus
);

  if (TIMEOUT_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("ingreso_pin: TIMEOUT_CYCLES must be >= 1 and below 2**CNT_W");
  end

  state_t           state, state_next;
  logic [PIN_W-1:0] pin_q, pin_next;
  logic             enter_q;
  logic [1:0]       dcount_q, dcount_next;
  logic             ocupado_q;
  logic             press;
  logic             en;
  logic             timeout;

  detector_flanco u_detector_flanco (
    .Clk   (Clk),
    .Reset (Reset),
    .level (bus.KeyValid),
    .rise  (press)
  );

  assign en = bus.Vehiculo & ~bus.Bloqueo;

`ifdef INGRESO_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt, cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign timeout = ((state == DIG1) || (state == DIG2)) && (cnt == CNT_LAST);

  // Idle counter: counts only while staying in DIG1/DIG2 without a press;
  // any press, any state change and any other state return it to zero.
  always_comb begin
    cnt_next = '0;
    if (((state_next == DIG1) || (state_next == DIG2)) &&
        (state_next == state) && !press)
      cnt_next = sat_inc(cnt);
  end

  // Idle counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt <= '0;
    else        cnt <= cnt_next;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next state and next Pin; priority is enable, then SEND exit, then
  // timeout, then key press.
  always_comb begin
    state_next = state;
    pin_next   = pin_q;
    if (!en) begin
      state_next = IDLE;
    end else if (state == SEND) begin
      state_next = IDLE;
    end else if (timeout) begin
      state_next = IDLE;
      pin_next   = '0;
    end else if (press) begin
      unique case (state)
        IDLE: begin
          if (is_digit(bus.Key)) begin
            pin_next   = {bus.Key, 4'h0};
            state_next = DIG1;
          end else if (bus.Key == KEY_CLEAR) begin
            pin_next = '0;
          end
        end
        DIG1: begin
          if (is_digit(bus.Key)) begin
            pin_next   = {pin_q[7:4], bus.Key};
            state_next = DIG2;
          end else if (bus.Key == KEY_CLEAR) begin
            pin_next   = '0;
            state_next = IDLE;
          end
        end
        DIG2: begin
          if (bus.Key == KEY_ENTER) begin
            state_next = SEND;
          end else if (bus.Key == KEY_CLEAR) begin
            pin_next   = '0;
            state_next = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit count follows the state being entered so it can be registered.
  always_comb begin
    dcount_next = 2'd0;
    unique case (state_next)
      DIG1:    dcount_next = 2'd1;
      DIG2:    dcount_next = 2'd2;
      default: dcount_next = 2'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      pin_q     <= '0;
      enter_q   <= 1'b0;
      dcount_q  <= 2'd0;
      ocupado_q <= 1'b0;
    end else begin
      state     <= state_next;
      pin_q     <= pin_next;
      enter_q   <= (state_next == SEND);
      dcount_q  <= dcount_next;
      ocupado_q <= (state_next != IDLE);
    end
  end

  assign bus.Pin        = pin_q;
  assign bus.enterPin   = enter_q;
  assign bus.DigitCount = dcount_q;
  assign bus.Ocupado    = ocupado_q;

endmodule

// File: tb/tb_ingreso_pin.sv
// Bench for ingreso_pin: directed keypad scenarios followed by randomized key
// traffic, all compared every cycle against a digit-list reference model.
module tb_ingreso_pin;

  localparam int TO = 10;
`ifdef INGRESO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  ingreso_pin_if bus ();

  ingreso_pin #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  // Reference model: the digits typed so far, the Pin value shown, whether an
  // Enter strobe is being shown, and how many cycles the entry has been idle.
  logic [3:0] digs[$];
  logic [7:0] m_pin;
  bit         m_send;
  int         m_idle;
  bit         m_kvp;

  function automatic void model_reset();
    digs.delete();
    m_pin  = 8'h00;
    m_send = 1'b0;
    m_idle = 0;
    m_kvp  = 1'b0;
  endfunction

  function automatic void model_step();
    bit pr;
    if (!Reset) begin
      model_reset();
      return;
    end
    pr    = bus.KeyValid && !m_kvp;
    m_kvp = bus.KeyValid;
    if (!(bus.Vehiculo && !bus.Bloqueo)) begin
      digs.delete();
      m_send = 1'b0;
      m_idle = 0;
    end else if (m_send) begin
      m_send = 1'b0;
      m_idle = 0;
    end else if (TO_EN && digs.size() != 0 && m_idle == TO - 1) begin
      digs.delete();
      m_pin  = 8'h00;
      m_idle = 0;
    end else if (pr) begin
      m_idle = 0;
      if (bus.Key <= 4'd9) begin
        if (digs.size() < 2) begin
          digs.push_back(bus.Key);
          if (digs.size() == 1) m_pin = {bus.Key, 4'h0};
          else                  m_pin = {digs[0], digs[1]};
        end
      end else if (bus.Key == 4'hA) begin
        digs.delete();
        m_pin = 8'h00;
      end else if (bus.Key == 4'hB && digs.size() == 2) begin
        digs.delete();
        m_send = 1'b1;
      end
    end else if (digs.size() != 0) begin
      m_idle++;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pin",      bus.Pin,                      m_pin);
    chk("enterpin", {7'd0, bus.enterPin},         {7'd0, m_send});
    chk("dcount",   {6'd0, bus.DigitCount},       8'(digs.size()));
    chk("ocupado",  {7'd0, bus.Ocupado},          {7'd0, (digs.size() != 0) || m_send});
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    check_all();
    if (bus.enterPin) pulses++;
  endtask

  task automatic press(input logic [3:0] k, input int hold = 3);
    bus.Key      = k;
    bus.KeyValid = 1'b1;
    repeat (hold) tick();
    bus.KeyValid = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    logic [7:0] exp_pin;
    logic [7:0] exp_dc;
    int rate;

    bus.Key      = 4'h0;
    bus.KeyValid = 1'b0;
    bus.Vehiculo = 1'b1;
    bus.Bloqueo  = 1'b0;
    model_reset();
    repeat (2) tick();
    Reset = 1'b1;
    tick();

    // 3, 7, Enter
    pulses = 0;
    press(4'h3);
    chk("a_dc1", {6'd0, bus.DigitCount}, 8'd1);
    press(4'h7);
    chk("a_dc2", {6'd0, bus.DigitCount}, 8'd2);
    chk("a_pin", bus.Pin, 8'h37);
    press(4'hB);
    chk("a_pin_after", bus.Pin, 8'h37);
    chk("a_dc0", {6'd0, bus.DigitCount}, 8'd0);
    chk("a_pulses", 8'(pulses), 8'd1);

    // 4, Enter (ignored), 9, 2 (ignored)
    pulses = 0;
    press(4'h4);
    press(4'hB);
    press(4'h9);
    press(4'h2);
    chk("b_pin", bus.Pin, 8'h49);
    chk("b_dc", {6'd0, bus.DigitCount}, 8'd2);
    chk("b_pulses", 8'(pulses), 8'd0);
    press(4'hA);

    // 5, Clear, 1, 6, Enter
    pulses = 0;
    press(4'h5);
    press(4'hA);
    chk("c_clear_pin", bus.Pin, 8'h00);
    press(4'h1);
    press(4'h6);
    press(4'hB);
    chk("c_pin", bus.Pin, 8'h16);
    chk("c_pulses", 8'(pulses), 8'd1);

    // Inactivity after a single digit
    exp_pin = TO_EN ? 8'h00 : 8'h80;
    exp_dc  = TO_EN ? 8'd0  : 8'd1;
    press(4'h8);
    repeat (10) tick();
    chk("t_pin", bus.Pin, exp_pin);
    chk("t_dc", {6'd0, bus.DigitCount}, exp_dc);
    press(4'hA);

    // Lockout before Enter
    pulses = 0;
    press(4'h2);
    press(4'h1);
    bus.Bloqueo = 1'b1;
    tick();
    press(4'hB);
    chk("l_pin", bus.Pin, 8'h21);
    chk("l_dc", {6'd0, bus.DigitCount}, 8'd0);
    chk("l_pulses", 8'(pulses), 8'd0);
    bus.Bloqueo = 1'b0;

    // Vehicle leaves in DIG2
    press(4'h2);
    press(4'h1);
    bus.Vehiculo = 1'b0;
    tick();
    press(4'hB);
    chk("v_pin", bus.Pin, 8'h21);
    chk("v_ocupado", {7'd0, bus.Ocupado}, 8'd0);
    chk("v_pulses", 8'(pulses), 8'd0);
    bus.Vehiculo = 1'b1;
    tick();

    // Asynchronous reset in DIG1
    press(4'h3);
    chk("r_pin_before", bus.Pin, 8'h30);
    #2 Reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("r_pin", bus.Pin, 8'h00);
    chk("r_dc", {6'd0, bus.DigitCount}, 8'd0);
    tick();
    Reset = 1'b1;
    tick();

    // Randomized key traffic
    rate = 4;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) rate = $urandom_range(2, 14);
      if (bus.KeyValid) begin
        if ($urandom_range(0, 2) == 0) bus.KeyValid = 1'b0;
      end else if ($urandom_range(0, rate - 1) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: bus.Key = 4'($urandom_range(0, 9));
          4, 5:       bus.Key = 4'hB;
          6:          bus.Key = 4'hA;
          default:    bus.Key = 4'($urandom_range(0, 15));
        endcase
        bus.KeyValid = 1'b1;
      end
      bus.Vehiculo = ($urandom_range(0, 29) != 0);
      bus.Bloqueo  = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ingreso_pin.md
Name: ingreso_pin

Overview:
Keypad front-end for the parking-gate controller. It collects two BCD digits from a keypad scanner and assembles them into the 8-bit Pin bus. When the driver presses Enter it issues a one-cycle enterPin strobe. It sits directly upstream of the gate controller and drives that controller's Pin and enterPin inputs. It gates entry on vehicle presence and on the controller's Bloqueo output.

Parameters:
TIMEOUT_CYCLES, 255, idle cycles in DIG1/DIG2 before partial entry is discarded (>=1)
CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Key  input  4  key code from scanner: 0x0-0x9 digit, 0xA Clear, 0xB Enter, 0xC-0xF ignored
KeyValid  input  1  high while a key is held; Key stable whenever KeyValid=1
Vehiculo  input  1  vehicle present at gate
Bloqueo  input  1  controller lockout; keypad disabled while high
Pin  output  8  assembled PIN, first digit [7:4], second digit [3:0]
enterPin  output  1  one-cycle strobe, Pin valid while high
DigitCount  output  2  digits currently held (0,1,2)
Ocupado  output  1  high in DIG1, DIG2, SEND

Behaviour:
- Reset (Reset=0, async): state IDLE; Pin=8'h00, enterPin=0, DigitCount=0, Ocupado=0, timeout counter=0, KeyValid history=0.
- Press detection: kv_q registers KeyValid each cycle. A press is accepted at the rising edge where KeyValid=1 and kv_q=0. Key is used as sampled on that edge. Holding a key gives exactly one press.
- Entry enable: en = Vehiculo & ~Bloqueo. If en=0, the state is forced to IDLE on the next edge: DigitCount=0, enterPin=0, no press accepted, Pin retains its last value. This rule has priority over every other transition.
- States:
  - IDLE: a digit press loads Pin[7:4]=Key and Pin[3:0]=0, then goes to DIG1. Clear sets Pin=0 and stays. Enter and codes 0xC-0xF are ignored.
  - DIG1: a digit press loads Pin[3:0]=Key and goes to DIG2. Clear goes to IDLE with Pin=0. Enter is ignored (incomplete PIN). On timeout: IDLE, Pin=0.
  - DIG2: Enter goes to SEND. Clear goes to IDLE with Pin=0. A further digit press is ignored (no shift, no overwrite). On timeout: IDLE, Pin=0.
  - SEND: enterPin=1 for exactly this one cycle, then unconditionally IDLE. Any press during SEND is ignored. Pin is held unchanged through SEND and into IDLE until the next digit or Clear.
- DigitCount: 0 in IDLE/SEND, 1 in DIG1, 2 in DIG2. Ocupado = state != IDLE.
- Latency: enterPin is high in the cycle following the edge that accepted Enter, i.e. registered with 1-cycle latency. Pin updates on the edge that accepts the digit.
- Timeout counter:
  - Cleared on every accepted press and on entry to DIG1.
  - Increments each cycle in DIG1/DIG2 and saturates.
  - Timeout fires on the edge where the counter equals TIMEOUT_CYCLES-1.
  - Counter is held at 0 outside DIG1/DIG2.
- Simultaneous events: en=0 beats timeout, which beats a key press. A press accepted on the timeout edge is dropped.
- Reset mid-entry: all state is discarded immediately; no enterPin is emitted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
INGRESO_TIMEOUT_EN.
- Defined: inactivity timeout as described; counter instantiated.
- Undefined: no counter logic. DIG1/DIG2 persist until Clear, Enter, digit, en=0 or reset. TIMEOUT_CYCLES and CNT_W are unused.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, DIG1=2'd1, DIG2=2'd2, SEND=2'd3) and key-code constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB.
- The same package also holds the PIN_W=8 constant, shared with the gate controller.
- One natural sub-module: detector_flanco (1-bit rising-edge detector on KeyValid). The FSM and counter stay in ingreso_pin.

Test Plan:
- Reset=0 mid-DIG1 with Pin=8'h30 -> immediately Pin=8'h00, DigitCount=0, Ocupado=0, enterPin stays 0.
- Vehiculo=1, Bloqueo=0; press 3, 7, Enter (each KeyValid high 3 cycles) -> Pin=8'h37; a single enterPin pulse 1 cycle after the Enter edge; DigitCount 1,2,0.
- Press 4, Enter, 9, 2 -> Enter ignored; third digit 2 ignored; Pin=8'h49, DigitCount=2, no enterPin.
- Press 5, Clear, 1, 6, Enter -> Pin=8'h00 after Clear; final Pin=8'h16 with one enterPin.
- With INGRESO_TIMEOUT_EN and TIMEOUT_CYCLES=10: press 8, then idle 10 cycles -> IDLE, Pin=8'h00. Repeat without the macro -> DIG1 persists, Pin=8'h80.
- Press 2, 1, then Bloqueo=1 before Enter, press Enter -> forced IDLE, no enterPin, Pin retains 8'h21; Vehiculo=0 in DIG2 gives the same result.
